filter_frame_ctrl: RTL and testbench

//  Frame sequencer for the single-clock 32-bit filter datapath (clk, reset, x -> y).

---
 rtl/filter_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_filter_frame_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for a free-running filter: clears filter state, streams one
// frame of samples into it, flushes the pipeline and tags results valid/last.
module filter_frame_ctrl #(
  parameter int WIDTH      = 32,
  parameter int FRAME_LEN  = 16,
  parameter int LAT        = 2,
  parameter int CLR_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             filt_reset,
  output logic [WIDTH-1:0] filt_x,
  input  logic [WIDTH-1:0] filt_y,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [WIDTH-1:0] filt_x_q, filt_x_d;
  logic [LAT:0]     tag_v_q, tag_v_d;
  logic [LAT:0]     tag_l_q, tag_l_d;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic             xfer_s;

  assign in_ready   = (state_q == S_RUN) && (cnt_q < CNT_W'(FRAME_LEN));
  assign xfer_s     = in_valid & in_ready;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign filt_reset = reset | (state_q == S_IDLE) | (state_q == S_CLEAR);
  assign filt_x     = filt_x_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;

  // Next state, sample count and the {valid,last} tag shift that tracks filt_x through the filter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_d    = clr_q;
    filt_x_d = '0;
    tag_v_d  = '0;
    tag_l_d  = '0;
    for (int i = LAT; i > 0; i--) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        clr_d = '0;
        if (start) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d = '0;
        if (clr_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end
      S_RUN: begin
        if (xfer_s) begin
          filt_x_d   = in_data;
          cnt_d      = cnt_q + CNT_W'(1);
          tag_v_d[0] = 1'b1;
          tag_l_d[0] = (cnt_q == CNT_W'(FRAME_LEN - 1));
        end else begin
          filt_x_d = '0;
        end
        // The final transfer leaves one RUN cycle with in_ready low before FLUSH
        if (cnt_q == CNT_W'(FRAME_LEN)) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (~|tag_v_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; out_data follows filt_y every edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clr_q       <= '0;
      filt_x_q    <= '0;
      tag_v_q     <= '0;
      tag_l_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      filt_x_q    <= filt_x_d;
      tag_v_q     <= tag_v_d;
      tag_l_q     <= tag_l_d;
      out_valid_q <= tag_v_q[LAT];
      out_last_q  <= tag_l_q[LAT];
      out_data_q  <= filt_y;
    end
  end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed bench for filter_frame_ctrl: a 4-sample-frame instance and a
// 1-sample-frame instance, each driving a behavioural LAT=2 filter.
module tb_filter_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        acc_mode = 1'b0;

  logic        start = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        busy, done, in_ready, filt_reset, out_valid, out_last;
  logic [31:0] filt_x, filt_y, out_data, s1;

  logic        start1 = 1'b0, in_valid1 = 1'b0;
  logic [31:0] in_data1 = 32'd0;
  logic        busy1, done1, in_ready1, filt_reset1, out_valid1, out_last1;
  logic [31:0] filt_x1, filt_y1, out_data1, s1b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] obs_data [$];
  logic        obs_last [$];
  int          obs_cyc  [$];
  int          done_q   [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  filter_frame_ctrl #(.WIDTH(32), .FRAME_LEN(4), .LAT(2), .CLR_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .filt_reset(filt_reset), .filt_x(filt_x), .filt_y(filt_y),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  filter_frame_ctrl #(.WIDTH(32), .FRAME_LEN(1), .LAT(2), .CLR_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .filt_reset(filt_reset1), .filt_x(filt_x1), .filt_y(filt_y1),
    .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1)
  );

  // Filter models: two-edge delay, or running sum when acc_mode is set
  always @(posedge clk) begin
    s1     <= filt_reset ? 32'd0 : (acc_mode ? s1 + filt_x : filt_x);
    filt_y <= s1;
    s1b     <= filt_reset1 ? 32'd0 : filt_x1;
    filt_y1 <= s1b;
  end

  // Record every tagged output and done pulse with its edge number
  always @(negedge clk) begin
    if (out_valid) begin
      obs_data.push_back(out_data);
      obs_last.push_back(out_last);
      obs_cyc.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    done_q.delete();
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    in_data  = 32'd0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick();
  endtask

  task automatic verify_frame(input string tag, input int o0, input int o1, input int o2, input int o3);
    int off [4];
    off = '{o0, o1, o2, o3};
    check_eq({tag, "_count"}, 32'(obs_data.size()), 32'd4);
    if (obs_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("%s_data%0d", tag, i), obs_data[i], 32'(i + 1));
        check_eq($sformatf("%s_last%0d", tag, i), 32'(obs_last[i]), 32'(i == 3));
        check_eq($sformatf("%s_gap%0d", tag, i), 32'(obs_cyc[i] - obs_cyc[0]), 32'(off[i]));
      end
    end
    check_eq({tag, "_done_count"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1 && obs_cyc.size() == 4) begin
      check_eq({tag, "_done_after_last"}, 32'(done_q[0]), 32'(obs_cyc[3] + 1));
    end
  endtask

  initial begin
    // Power-on reset
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_filt_reset", 32'(filt_reset), 32'd1);
    check_eq("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    tick();

    // 1: reset mid-RUN
    start_frame();
    send(32'd11);
    send(32'd12);
    clear_obs();
    reset = 1'b1;
    repeat (3) tick();
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_done", 32'(done), 32'd0);
    check_eq("t1_in_ready", 32'(in_ready), 32'd0);
    check_eq("t1_out_valid", 32'(out_valid), 32'd0);
    check_eq("t1_out_last", 32'(out_last), 32'd0);
    check_eq("t1_out_data", out_data, 32'd0);
    check_eq("t1_filt_x", filt_x, 32'd0);
    check_eq("t1_filt_reset", 32'(filt_reset), 32'd1);
    reset = 1'b0;
    repeat (6) tick();
    check_eq("t1_no_out_after", 32'(obs_data.size()), 32'd0);
    check_eq("t1_busy_after", 32'(busy), 32'd0);

    // 2: back-to-back frame with cycle-exact checks
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t2_clear_busy", 32'(busy), 32'd1);
    check_eq("t2_clear_filt_reset", 32'(filt_reset), 32'd1);
    check_eq("t2_clear_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("t2_run_in_ready", 32'(in_ready), 32'd1);
    check_eq("t2_run_filt_reset", 32'(filt_reset), 32'd0);
    send(32'd1);
    check_eq("t2_filt_x1", filt_x, 32'd1);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    check_eq("t2_full_in_ready", 32'(in_ready), 32'd0);
    check_eq("t2_first_valid", 32'(out_valid), 32'd1);
    check_eq("t2_first_data", out_data, 32'd1);
    tick();
    check_eq("t2_flush_filt_x", filt_x, 32'd0);
    tick();
    tick();
    check_eq("t2_last_valid", 32'(out_valid), 32'd1);
    check_eq("t2_last_data", out_data, 32'd4);
    check_eq("t2_last_flag", 32'(out_last), 32'd1);
    check_eq("t2_done_early", 32'(done), 32'd0);
    tick();
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_done_valid", 32'(out_valid), 32'd0);
    check_eq("t2_done_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t2_idle_done", 32'(done), 32'd0);
    check_eq("t2_idle_busy", 32'(busy), 32'd0);
    verify_frame("t2", 0, 1, 2, 3);

    // 3: two-cycle bubble between samples 2 and 3
    clear_obs();
    start_frame();
    send(32'd1);
    send(32'd2);
    tick();
    tick();
    send(32'd3);
    send(32'd4);
    wait_done("t3");
    verify_frame("t3", 0, 1, 4, 5);

    // 4: start pulsed in RUN and in DONE is ignored; start in IDLE launches
    clear_obs();
    start_frame();
    send(32'd1);
    send(32'd2);
    start = 1'b1;
    send(32'd3);
    start = 1'b0;
    send(32'd4);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 15 && !seen; i++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check_eq("t4_done_seen", 32'(seen), 32'd1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t4_idle_after_done", 32'(busy), 32'd0);
    tick();
    check_eq("t4_still_idle", 32'(busy), 32'd0);
    verify_frame("t4", 0, 1, 2, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t4_idle_start", 32'(busy), 32'd1);
    tick();
    clear_obs();
    for (int i = 1; i <= 4; i++) send(32'(i));
    wait_done("t4b");
    verify_frame("t4b", 0, 1, 2, 3);

    // 5: accumulator filter, history cleared between frames
    acc_mode = 1'b1;
    for (int f = 0; f < 2; f++) begin
      clear_obs();
      start_frame();
      for (int i = 0; i < 4; i++) send(32'd1);
      wait_done($sformatf("t5f%0d", f));
      verify_frame($sformatf("t5f%0d", f), 0, 1, 2, 3);
    end
    acc_mode = 1'b0;

    // 6: single-sample frame
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check_eq("t6_in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1;
    in_data1  = 32'd7;
    tick();
    in_valid1 = 1'b0;
    in_data1  = 32'd0;
    check_eq("t6_full_in_ready", 32'(in_ready1), 32'd0);
    tick();
    check_eq("t6_early_valid_a", 32'(out_valid1), 32'd0);
    tick();
    check_eq("t6_early_valid_b", 32'(out_valid1), 32'd0);
    tick();
    check_eq("t6_valid", 32'(out_valid1), 32'd1);
    check_eq("t6_last", 32'(out_last1), 32'd1);
    check_eq("t6_data", out_data1, 32'd7);
    check_eq("t6_done_early", 32'(done1), 32'd0);
    tick();
    check_eq("t6_done", 32'(done1), 32'd1);
    check_eq("t6_valid_after", 32'(out_valid1), 32'd0);
    tick();
    check_eq("t6_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
